fib_display_driver: RTL and testbench

//  Upstream stage for the 7-segment decoder. Generates the Fibonacci sequence in binary,

---
 rtl/fib_disp_pkg.sv | 20 ++
 rtl/fib_display_driver_bin2bcd_seq.sv | 78 +++++++
 rtl/fib_display_driver.sv | 149 ++++++++++++++
 tb/tb_fib_display_driver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_disp_pkg.sv
// Shared constants, converter state encoding and anode helper for the
// Fibonacci display driver.
package fib_disp_pkg;

   localparam int LIMIT_DEFAULT = 9999;
   localparam int BCD_DIGITS    = 4;
   localparam int BIN_W         = 16;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD
   } conv_state_t;

   // Active-low one-hot anode select for the given digit index.
   function automatic logic [BCD_DIGITS-1:0] anode_onehot_n(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/fib_display_driver_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock.
// start loads the operand, 16 SHIFT cycles build the digits, LOAD presents
// them on bcd_out with done high. abort drops a conversion in progress; abort
// together with start restarts on the new operand.
module bin2bcd_seq
   import fib_disp_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [BIN_W-1:0] bcd_out
);

   localparam int          SR_W     = 2 * BIN_W;
   localparam logic [3:0]  CNT_LAST = 4'(BIN_W - 1);

   conv_state_t      state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [BIN_W-1:0] bcd_adj;

   // Add 3 to every BCD digit that is 5 or more before the next shift.
   generate
      for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
         logic [3:0] dig;
         assign dig = sr_q[BIN_W + 4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
      end
   endgenerate

   // Next-state: shift while in SHIFT, start/abort take priority.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      case (state_q)
         SHIFT: begin
            sr_d  = {bcd_adj[BIN_W-2:0], sr_q[BIN_W-1:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = LOAD;
            end
         end
         LOAD:    state_d = IDLE;
         default: ;
      endcase
      if (start && (state_q == IDLE || abort)) begin
         sr_d    = {{BIN_W{1'b0}}, bin_in};
         cnt_d   = '0;
         state_d = SHIFT;
      end else if (abort) begin
         cnt_d   = '0;
         state_d = IDLE;
      end
   end

   // State, bit counter and shift register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == LOAD) && !abort;
   assign bcd_out = sr_q[SR_W-1:BIN_W];

endmodule

// File: rtl/fib_display_driver.sv
// Fibonacci term generator feeding a 4-digit multiplexed BCD display.
// Terms advance every STEP_DIV enabled cycles, each new term is converted to
// BCD in the background, and the display register only changes when a
// conversion completes, so the scanned digits never show a partial value.
module fib_display_driver
   import fib_disp_pkg::*;
#(
   parameter int STEP_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000,
   parameter int LIMIT    = LIMIT_DEFAULT
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        restart,
   output logic [3:0]  fibonacci,
   output logic [3:0]  an,
   output logic [15:0] value,
   output logic        bcd_valid
);

   localparam int STEP_W = $clog2(STEP_DIV);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
   localparam logic [16:0]       LIMIT_V   = 17'(LIMIT);

   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [15:0]       a_q, a_d;
   logic [16:0]       b_q, b_d;
   logic              pending_q, pending_d;
   logic [15:0]       disp_q, disp_d;
   logic              bcd_valid_q, bcd_valid_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        fib_q, fib_d;
   logic [3:0]        an_q, an_d;

   logic              step_tick;
   logic [16:0]       sum;
   logic              conv_start, conv_abort, conv_busy, conv_done;
   logic [15:0]       conv_bin, conv_bcd;

   bin2bcd_seq u_conv (
      .clock   (clock),
      .reset   (reset),
      .start   (conv_start),
      .abort   (conv_abort),
      .bin_in  (conv_bin),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd_out (conv_bcd)
   );

   // Step timer, term update, pending step and converter kick-off.
   always_comb begin
      step_cnt_d = step_cnt_q;
      step_tick  = 1'b0;
      if (enable) begin
         if (step_cnt_q == STEP_LAST) begin
            step_tick  = 1'b1;
            step_cnt_d = '0;
         end else begin
            step_cnt_d = step_cnt_q + STEP_ONE;
         end
      end
      sum        = {1'b0, a_q} + b_q;
      a_d        = a_q;
      b_d        = b_q;
      pending_d  = pending_q;
      conv_start = 1'b0;
      conv_abort = 1'b0;
      conv_bin   = b_q[15:0];
      if (restart) begin
         a_d        = '0;
         b_d        = 17'd1;
         pending_d  = 1'b0;
         step_cnt_d = '0;
         conv_abort = 1'b1;
         conv_start = 1'b1;
         conv_bin   = '0;
      end else if ((step_tick || pending_q) && !conv_busy) begin
         pending_d  = 1'b0;
         conv_start = 1'b1;
         if (b_q > LIMIT_V) begin
            // Next term would exceed the display range: restart at 0, 1.
            a_d      = '0;
            b_d      = 17'd1;
            conv_bin = '0;
         end else begin
            a_d      = b_q[15:0];
            b_d      = sum;
            conv_bin = b_q[15:0];
         end
      end else if (step_tick) begin
         pending_d = 1'b1;
      end
   end

   // Display load, digit scan and registered nibble/anode outputs.
   always_comb begin
      disp_d      = conv_done ? conv_bcd : disp_q;
      bcd_valid_d = conv_done;
      scan_cnt_d  = scan_cnt_q + SCAN_ONE;
      idx_d       = idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end
      // Nibble and anode come from the same next-state index so they always agree.
      fib_d = disp_d[4*idx_d +: 4];
      an_d  = anode_onehot_n(idx_d);
   end

   // All top-level state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_cnt_q  <= '0;
         a_q         <= '0;
         b_q         <= 17'd1;
         pending_q   <= 1'b0;
         disp_q      <= '0;
         bcd_valid_q <= 1'b0;
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         fib_q       <= '0;
         an_q        <= 4'b1110;
      end else begin
         step_cnt_q  <= step_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pending_q   <= pending_d;
         disp_q      <= disp_d;
         bcd_valid_q <= bcd_valid_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         fib_q       <= fib_d;
         an_q        <= an_d;
      end
   end

   assign value     = a_q;
   assign bcd_valid = bcd_valid_q;
   assign fibonacci = fib_q;
   assign an        = an_q;

endmodule

// File: tb/tb_fib_display_driver.sv
// Scoreboard bench for fib_display_driver: the stimulus process keeps a
// term-table reference model and queues expected values and display loads;
// an independent monitor pops and compares them on every falling edge.
module tb_fib_display_driver;

   localparam int STEP_DIV = 40;
   localparam int SCAN_DIV = 4;
   localparam int NFIB     = 21;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        restart = 1'b0;
   logic [3:0]  fibonacci;
   logic [3:0]  an;
   logic [15:0] value;
   logic        bcd_valid;

   fib_display_driver #(.STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV), .LIMIT(9999)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .restart   (restart),
      .fibonacci (fibonacci),
      .an        (an),
      .value     (value),
      .bcd_valid (bcd_valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   exp_t val_q[$];
   exp_t bcd_q[$];
   int   fib_tab[NFIB];
   int   cyc = 0;
   int   k = 0;
   int   mcnt = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int an_idx(logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   // One cycle of stimulus; the model predicts the effect of the closing edge.
   task automatic run_cycle(input bit en, input bit rs);
      bit   rs_eff;
      bit   tick;
      exp_t e;
      exp_t keep[$];
      @(posedge clock);
      cyc++;
      #1;
      rs_eff = rs;
      foreach (bcd_q[i]) if (bcd_q[i].due == cyc + 1) rs_eff = 1'b0;
      enable  = en;
      restart = rs_eff;
      tick = en && (mcnt == STEP_DIV - 1);
      if (rs_eff) begin
         k    = 0;
         mcnt = 0;
         foreach (bcd_q[i]) if (bcd_q[i].due <= cyc) keep.push_back(bcd_q[i]);
         bcd_q  = keep;
         e.due  = cyc + 18;
         e.data = to_bcd(0);
         bcd_q.push_back(e);
      end else if (en) begin
         if (tick) begin
            mcnt   = 0;
            k      = (k + 1) % NFIB;
            e.due  = cyc + 18;
            e.data = to_bcd(fib_tab[k]);
            bcd_q.push_back(e);
         end else begin
            mcnt++;
         end
      end
      e.due  = cyc + 1;
      e.data = 16'(fib_tab[k]);
      val_q.push_back(e);
   endtask

   task automatic idle_cycle();
      @(posedge clock);
      cyc++;
      #1;
      enable  = 1'b0;
      restart = 1'b0;
   endtask

   task automatic release_reset();
      exp_t e;
      @(posedge clock);
      cyc++;
      #1;
      reset   = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      val_q.delete();
      bcd_q.delete();
      k    = 0;
      mcnt = 0;
      e.data = '0;
      e.due  = cyc;
      val_q.push_back(e);
      e.due  = cyc + 1;
      val_q.push_back(e);
   endtask

   task automatic run_until_k(input int target, input string name);
      int guard = 0;
      while (k != target && guard < 3000) begin
         run_cycle(1'b1, 1'b0);
         guard++;
      end
      check(name, 32'(k == target), 32'd1);
   endtask

   // Monitor: value every cycle, display loads on bcd_valid, scanned digits and anode timing.
   initial begin
      logic [3:0]  prev_an = 4'b1110;
      int          hold = 0;
      logic [15:0] mdisp = '0;
      exp_t        e;
      int          d;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_an = 4'b1110;
            hold    = 0;
            mdisp   = '0;
         end else begin
            if (val_q.size() > 0 && val_q[0].due == cyc) begin
               e = val_q.pop_front();
               check("value", value, e.data);
            end
            if (bcd_valid) begin
               if (bcd_q.size() == 0) begin
                  check("bcd_valid_unexpected", 32'd1, 32'd0);
               end else begin
                  e = bcd_q.pop_front();
                  check("bcd_valid_cycle", cyc, e.due);
                  mdisp = e.data;
                  $display("[cycle %0d] bcd_valid value=%0d digits=%h", cyc, value, e.data);
               end
            end
            if (bcd_q.size() > 0 && bcd_q[0].due < cyc) begin
               e = bcd_q.pop_front();
               check("bcd_valid_missing", 32'd0, 32'(e.data));
            end
            d = an_idx(an);
            check("an_onehot", 32'(d >= 0), 32'd1);
            if (d >= 0) check("fibonacci_digit", fibonacci, mdisp[4*d +: 4]);
            if (an == prev_an) begin
               hold++;
            end else begin
               check("scan_hold", hold, SCAN_DIV);
               check("scan_order", an, {prev_an[2:0], prev_an[3]});
               hold    = 1;
               prev_an = an;
            end
         end
      end
   end

   // Stimulus: directed scenarios, then randomized run, then reset mid-scan.
   initial begin
      int         f0, f1, t;
      int         v0;
      int         changes;
      logic [3:0] last_an;
      int         seen[4];
      int         exp_dig[4];
      f0 = 0;
      f1 = 1;
      for (int i = 0; i < NFIB; i++) begin
         fib_tab[i] = f0;
         t  = f0 + f1;
         f0 = f1;
         f1 = t;
      end

      repeat (3) idle_cycle();
      release_reset();

      // Eight steps reach 21; scan shows 1,2,0,0 on the four anodes.
      repeat (8 * STEP_DIV + 20) run_cycle(1'b1, 1'b0);
      check("value_after_8_steps", value, 16'd21);
      exp_dig = '{1, 2, 0, 0};
      seen    = '{-1, -1, -1, -1};
      for (int i = 0; i < 16; i++) begin
         run_cycle(1'b1, 1'b0);
         if (an_idx(an) >= 0) seen[an_idx(an)] = int'(fibonacci);
      end
      for (int i = 0; i < 4; i++) check("digit_of_21", seen[i], exp_dig[i]);

      // Run to the largest term, then wrap through 0 and 1.
      run_until_k(20, "reach_6765");
      run_cycle(1'b1, 1'b0);
      check("value_6765", value, 16'd6765);
      run_until_k(0, "reach_wrap");
      run_cycle(1'b1, 1'b0);
      check("value_wrap_0", value, 16'd0);
      run_until_k(1, "reach_1");
      run_cycle(1'b1, 1'b0);
      check("value_after_wrap_1", value, 16'd1);
      repeat (20) run_cycle(1'b1, 1'b0);

      // Frozen term while enable is low; scanning keeps cycling.
      v0      = int'(value);
      changes = 0;
      last_an = an;
      repeat (200) begin
         run_cycle(1'b0, 1'b0);
         if (an != last_an) changes++;
         last_an = an;
      end
      check("value_frozen", value, 16'(v0));
      check("scan_changes_frozen", changes, 200 / SCAN_DIV);

      // Restart in cycle 5 of the 6765 conversion: that load never appears.
      run_until_k(20, "reach_6765_again");
      repeat (4) run_cycle(1'b1, 1'b0);
      run_cycle(1'b1, 1'b1);
      repeat (25) run_cycle(1'b1, 1'b0);
      check("value_after_restart", value, 16'd0);

      // Restart coinciding with a step tick: the step is discarded.
      repeat (3 * STEP_DIV) run_cycle(1'b1, 1'b0);
      t = 0;
      while (mcnt != STEP_DIV - 1 && t < 200) begin
         run_cycle(1'b1, 1'b0);
         t++;
      end
      run_cycle(1'b1, 1'b1);
      run_cycle(1'b1, 1'b0);
      check("value_restart_vs_tick", value, 16'd0);
      repeat (60) run_cycle(1'b1, 1'b0);
      check("value_one_step_after_restart", value, 16'd1);

      // Randomized enable and occasional restart.
      repeat (3000) run_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 299) == 0);

      // Asynchronous reset between clock edges.
      @(posedge clock);
      cyc++;
      #3;
      reset = 1'b1;
      #1;
      check("reset_an", an, 4'b1110);
      check("reset_fibonacci", fibonacci, 4'd0);
      check("reset_value", value, 16'd0);
      check("reset_bcd_valid", bcd_valid, 1'b0);
      repeat (2) idle_cycle();
      release_reset();
      repeat (100) run_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0);
      repeat (30) run_cycle(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
